// File: rtl/led_matrix_scanner_if.sv
// Frame handshake and LED drive bundle for the 8x8 matrix scanner.
// master = frame source / panel side, slave = the scanner itself.
`timescale 1ns/1ps
interface led_matrix_scanner_if;
   logic [63:0] frame_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;

   modport master (
      output frame_in,
      output frame_valid,
      input  frame_ready,
      input  row_sel,
      input  col_data,
      input  frame_done
   );

   modport slave (
      input  frame_in,
      input  frame_valid,
      output frame_ready,
      output row_sel,
      output col_data,
      output frame_done
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 LED matrix row scanner: a shadow frame is accepted over a
// valid/ready handshake and swapped into the displayed buffer only at frame boundaries.
`timescale 1ns/1ps
module led_matrix_scanner #(
   parameter int DWELL_CYCLES = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   led_matrix_scanner_if.slave  frame_bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
   localparam logic [3:0] BLANK_LAST = 4'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   localparam bit         NO_BLANK   = (BLANK_CYCLES == 0);

   state_t      state;
   logic [2:0]  row;
   logic [7:0]  dwell;
   logic [3:0]  blank_cnt;
   logic        pending;
   logic        active_valid;
   logic [63:0] shadow;
   logic [63:0] active;
   logic [7:0]  row_drive;
   logic [7:0]  col_drive;
   logic        done_pulse;

   logic        accept;
   logic        advance;
   logic        wrap_row;
   logic        swap;
   logic [2:0]  next_row;
   logic [63:0] next_frame;

   function automatic logic [7:0] row_bits(input logic [63:0] frame, input logic [2:0] r);
      return frame[{r, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] one_hot(input logic [2:0] r);
      return 8'b1 << r;
   endfunction

   assign accept     = frame_bus.frame_valid && !pending;
   // Row step happens either from the last dwell cycle (no blanking) or the last blank cycle.
   assign advance    = (state == SCAN  && dwell == DWELL_LAST && NO_BLANK) ||
                       (state == BLANK && blank_cnt == BLANK_LAST);
   assign wrap_row   = (row == 3'd7);
   assign next_row   = row + 3'd1;
   assign swap       = wrap_row && pending;
   assign next_frame = swap ? shadow : active;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         row          <= 3'd0;
         dwell        <= 8'd0;
         blank_cnt    <= 4'd0;
         pending      <= 1'b0;
         active_valid <= 1'b0;
         shadow       <= 64'd0;
         active       <= 64'd0;
         row_drive    <= 8'd0;
         col_drive    <= 8'd0;
         done_pulse   <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         // Acceptance and swap are mutually exclusive: one needs pending=0, the other pending=1.
         if (accept) begin
            shadow  <= frame_bus.frame_in;
            pending <= 1'b1;
         end
         if (!en) begin
            state     <= IDLE;
            row       <= 3'd0;
            dwell     <= 8'd0;
            blank_cnt <= 4'd0;
            row_drive <= 8'd0;
            col_drive <= 8'd0;
         end else if (advance) begin
            state     <= SCAN;
            row       <= next_row;
            dwell     <= 8'd0;
            blank_cnt <= 4'd0;
            row_drive <= one_hot(next_row);
            col_drive <= row_bits(next_frame, next_row);
            if (wrap_row) begin
               done_pulse <= 1'b1;
            end
            if (swap) begin
               active  <= shadow;
               pending <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (pending || active_valid) begin
                     state     <= SCAN;
                     row       <= 3'd0;
                     dwell     <= 8'd0;
                     blank_cnt <= 4'd0;
                     row_drive <= 8'h01;
                     if (pending) begin
                        active       <= shadow;
                        pending      <= 1'b0;
                        active_valid <= 1'b1;
                        col_drive    <= row_bits(shadow, 3'd0);
                     end else begin
                        col_drive    <= row_bits(active, 3'd0);
                     end
                  end
               end
               SCAN: begin
                  if (dwell == DWELL_LAST) begin
                     state     <= BLANK;
                     dwell     <= 8'd0;
                     blank_cnt <= 4'd0;
                     row_drive <= 8'd0;
                     col_drive <= 8'd0;
                  end else begin
                     dwell <= dwell + 8'd1;
                  end
               end
               BLANK: begin
                  blank_cnt <= blank_cnt + 4'd1;
               end
               default: begin
                  state     <= IDLE;
                  row_drive <= 8'd0;
                  col_drive <= 8'd0;
               end
            endcase
         end
      end
   end

   assign frame_bus.frame_ready = ~pending;
   assign frame_bus.row_sel     = row_drive;
   assign frame_bus.col_data    = col_drive;
   assign frame_bus.frame_done  = done_pulse;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: two instances (4/1 and 1/0 timing) checked every
// cycle against a position-in-frame reference model plus directed scenario checks.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        frame_valid = 1'b0;
   logic [63:0] frame_in = 64'd0;

   always #5 clk = ~clk;

   led_matrix_scanner_if bus0 ();
   led_matrix_scanner_if bus1 ();

   assign bus0.frame_in    = frame_in;
   assign bus0.frame_valid = frame_valid;
   assign bus1.frame_in    = frame_in;
   assign bus1.frame_valid = frame_valid;

   led_matrix_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .en(en), .frame_bus(bus0)
   );
   led_matrix_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .en(en), .frame_bus(bus1)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Reference model: display position p within the frame period, buffers and flags.
   int          cfg_d [2] = '{4, 1};
   int          cfg_b [2] = '{1, 0};
   bit          m_run [2];
   bit          m_pend[2];
   bit          m_av  [2];
   bit          m_done[2];
   int          m_p   [2];
   logic [63:0] m_act [2];
   logic [63:0] m_sh  [2];

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkint(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 0; m_pend[k] = 0; m_av[k] = 0; m_done[k] = 0;
         m_p[k] = 0; m_act[k] = 64'd0; m_sh[k] = 64'd0;
      end
   endtask

   task automatic model_tick(input int k, input bit e, input bit fv, input logic [63:0] fi);
      bit          acc;
      bit          old_pend;
      logic [63:0] old_sh;
      int          period;
      acc      = fv && !m_pend[k];
      old_pend = m_pend[k];
      old_sh   = m_sh[k];
      period   = 8 * (cfg_d[k] + cfg_b[k]);
      m_done[k] = 0;
      if (!e) begin
         m_run[k] = 0;
      end else if (!m_run[k]) begin
         if (old_pend || m_av[k]) begin
            m_run[k] = 1;
            m_p[k]   = 0;
            if (old_pend) begin
               m_act[k] = old_sh; m_pend[k] = 0; m_av[k] = 1;
            end
         end
      end else begin
         m_p[k] = (m_p[k] + 1) % period;
         if (m_p[k] == 0) begin
            m_done[k] = 1;
            if (old_pend) begin
               m_act[k] = old_sh; m_pend[k] = 0;
            end
         end
      end
      if (acc) begin
         m_sh[k] = fi; m_pend[k] = 1;
      end
   endtask

   task automatic compare_all();
      int          slot;
      int          r;
      logic [63:0] f;
      logic [7:0]  e_rs, e_cd, o_rs, o_cd;
      logic        o_done, o_rdy;
      for (int k = 0; k < 2; k++) begin
         slot = cfg_d[k] + cfg_b[k];
         e_rs = 8'd0;
         e_cd = 8'd0;
         if (m_run[k] && (m_p[k] % slot) < cfg_d[k]) begin
            r    = (m_p[k] / slot) % 8;
            e_rs = 8'(1 << r);
            f    = m_act[k] >> (8 * r);
            e_cd = f[7:0];
         end
         o_rs   = (k == 0) ? bus0.row_sel     : bus1.row_sel;
         o_cd   = (k == 0) ? bus0.col_data    : bus1.col_data;
         o_done = (k == 0) ? bus0.frame_done  : bus1.frame_done;
         o_rdy  = (k == 0) ? bus0.frame_ready : bus1.frame_ready;
         check8($sformatf("row_sel%0d", k),     o_rs, e_rs);
         check8($sformatf("col_data%0d", k),    o_cd, e_cd);
         check8($sformatf("frame_done%0d", k),  {7'd0, o_done}, {7'd0, m_done[k]});
         check8($sformatf("frame_ready%0d", k), {7'd0, o_rdy},  {7'd0, !m_pend[k]});
      end
   endtask

   // One clock: sample inputs, advance the model at the edge, compare just after it.
   task automatic step();
      bit          e, fv, r;
      logic [63:0] fi;
      e  = en;
      fv = frame_valid;
      fi = frame_in;
      r  = rst;
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (!r) model_reset();
         else    model_tick(k, e, fv, fi);
      end
      #1;
      compare_all();
   endtask

   initial begin
      int          load_cyc;
      int          done0[$];
      int          done1[$];
      logic [63:0] frame_a;
      logic [63:0] frame_b;
      logic [63:0] frame_x;

      model_reset();
      #1 rst = 1'b0;
      #1;
      compare_all();
      step();
      step();
      check8("reset_ready", {7'd0, bus0.frame_ready}, 8'd1);
      check8("reset_rowsel", bus0.row_sel, 8'd0);
      rst = 1'b1;
      step();

      // Basic scan with the diagonal frame.
      en          = 1'b1;
      frame_in    = 64'h8040201008040201;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      check8("handshake_no_row_yet", bus0.row_sel, 8'h00);
      step();
      check8("first_row0", bus0.row_sel, 8'h01);
      check8("first_row1", bus1.row_sel, 8'h01);
      check8("first_no_done", {7'd0, bus0.frame_done}, 8'd0);
      load_cyc = cyc;
      for (int i = 0; i < 90; i++) begin
         step();
         if (bus0.frame_done === 1'b1) done0.push_back(cyc - load_cyc);
         if (bus1.frame_done === 1'b1) done1.push_back(cyc - load_cyc);
      end
      checkint("done0_count", done0.size(), 2);
      checkint("done0_first", (done0.size() > 0) ? done0[0] : -1, 40);
      checkint("done0_period", (done0.size() > 1) ? done0[1] - done0[0] : -1, 40);
      checkint("done1_count", done1.size(), 11);
      checkint("done1_first", (done1.size() > 0) ? done1[0] : -1, 8);
      checkint("done1_period", (done1.size() > 1) ? done1[1] - done1[0] : -1, 8);

      // Backpressure: frame A pending, frame B offered continuously until the swap.
      frame_a     = {$urandom, $urandom};
      frame_b     = {$urandom, $urandom};
      frame_in    = frame_a;
      frame_valid = 1'b1;
      step();
      frame_in = frame_b;
      step();
      check8("backpressure_ready", {7'd0, bus0.frame_ready}, 8'd0);
      for (int i = 0; i < 50 && bus0.frame_done !== 1'b1; i++) step();
      check8("wait_swap_a", {7'd0, bus0.frame_done}, 8'd1);
      check8("swap_shows_a", bus0.col_data, frame_a[7:0]);
      check8("swap_frees_ready", {7'd0, bus0.frame_ready}, 8'd1);
      step();
      frame_valid = 1'b0;
      check8("b_accepted", {7'd0, bus0.frame_ready}, 8'd0);
      step();
      for (int i = 0; i < 50 && bus0.frame_done !== 1'b1; i++) step();
      check8("wait_swap_b", {7'd0, bus0.frame_done}, 8'd1);
      check8("swap_shows_b", bus0.col_data, frame_b[7:0]);

      // Mid-frame update during row 3.
      for (int i = 0; i < 50 && bus0.row_sel !== 8'h08; i++) step();
      check8("wait_row3", bus0.row_sel, 8'h08);
      frame_in    = 64'hFFFF_FFFF_FFFF_FFFF;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      check8("row3_still_old", bus0.col_data, frame_b[31:24]);
      for (int i = 0; i < 50 && bus0.frame_done !== 1'b1; i++) step();
      check8("wait_swap_ff", {7'd0, bus0.frame_done}, 8'd1);
      check8("new_frame_row0", bus0.col_data, 8'hFF);

      // Enable gating during row 5.
      for (int i = 0; i < 50 && bus0.row_sel !== 8'h20; i++) step();
      check8("wait_row5", bus0.row_sel, 8'h20);
      en = 1'b0;
      step();
      check8("en_off_rowsel", bus0.row_sel, 8'h00);
      check8("en_off_col", bus0.col_data, 8'h00);
      step();
      step();
      en = 1'b1;
      step();
      check8("en_on_row0", bus0.row_sel, 8'h01);
      check8("en_on_col", bus0.col_data, 8'hFF);
      check8("en_on_no_done", {7'd0, bus0.frame_done}, 8'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         en          = ($urandom_range(0, 19) != 0);
         frame_valid = ($urandom_range(0, 3) == 0);
         frame_in    = {$urandom, $urandom};
         step();
      end
      en          = 1'b1;
      frame_valid = 1'b0;

      // Asynchronous reset in the middle of a blank interval.
      for (int i = 0; i < 20 && bus0.row_sel === 8'h00; i++) step();
      for (int i = 0; i < 10 && bus0.row_sel !== 8'h00; i++) step();
      check8("wait_blank_rowsel", bus0.row_sel, 8'h00);
      #2 rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      check8("async_ready", {7'd0, bus0.frame_ready}, 8'd1);
      #1 rst = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check8("post_reset_idle", bus0.row_sel, 8'h00);
      frame_x     = {$urandom, $urandom};
      frame_in    = frame_x;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      step();
      check8("post_reset_row0", bus0.row_sel, 8'h01);
      check8("post_reset_col0", bus0.col_data, frame_x[7:0]);
      for (int i = 0; i < 20; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
